// File: rtl/fan_ctrl_pkg.sv
// fan_ctrl_pkg: shared state encoding, level limits and the temp-to-target mapping
package fan_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, UP, DOWN, OT} fan_state_t;
   localparam logic [3:0] LEVEL_MAX     = 4'hF;
   localparam logic [3:0] DEF_ON_THRESH = 4'd8;
   localparam logic [3:0] DEF_OT_THRESH = 4'd13;
   // Over-temperature wins over enable; codes below on_th give an idle fan
   function automatic logic [3:0] fan_target(input logic [3:0] t, input logic en,
                                             input logic [3:0] on_th, input logic [3:0] ot_th);
      return (t >= ot_th) ? LEVEL_MAX : (!en || t < on_th) ? 4'h0 : t - on_th + 4'd1;
   endfunction
endpackage

// File: rtl/fan_step_timer.sv
// fan_step_timer: free-running ramp step counter with sync clear, ticks at RAMP_DIV-1
module fan_step_timer #(
   parameter int RAMP_DIV = 4,
   parameter int CNT_W    = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_DIV - 1);
   logic [CNT_W-1:0] cnt;
   assign tick = cnt == LAST;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fan_ramp_ctrl.sv
// fan_ramp_ctrl: ramps the applied fan level toward a temperature target, forcing full speed on over-temp
// FAN_CTRL_HYST_EN: when defined, IDLE ignores a target exactly one level below the current level
module fan_ramp_ctrl
   import fan_ctrl_pkg::*;
#(
   parameter int         RAMP_DIV  = 4,
   parameter logic [3:0] ON_THRESH = DEF_ON_THRESH,
   parameter logic [3:0] OT_THRESH = DEF_OT_THRESH,
   parameter int         CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       temp_valid,
   input  logic [3:0] temp,
   output logic [3:0] fan_level,
   output logic       fan_on,
   output logic       overtemp,
   output logic       ramping
);
   localparam logic [3:0] OT_HOLD = OT_THRESH - 4'd1;
   fan_state_t state, state_nxt;
   logic [3:0] temp_q, target, level_nxt;
   logic       ot_hit, dn_ok, tick, clr;
   assign target = fan_target(temp_q, enable, ON_THRESH, OT_THRESH);
   assign ot_hit = temp_q >= OT_THRESH;
`ifdef FAN_CTRL_HYST_EN
   assign dn_ok = target < fan_level && (target == 4'd0 || {1'b0, target} + 5'd2 <= {1'b0, fan_level});
`else
   assign dn_ok = target < fan_level;
`endif
   fan_step_timer #(.RAMP_DIV(RAMP_DIV), .CNT_W(CNT_W)) u_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .tick (tick)
   );
   // Timer only runs while ramping; every other state holds it at zero so UP/DOWN start fresh
   always_comb begin
      state_nxt = state;
      level_nxt = fan_level;
      clr       = 1'b1;
      if (ot_hit && state != OT) begin
         state_nxt = OT;
         level_nxt = LEVEL_MAX;
      end else begin
         case (state)
            IDLE: state_nxt = (target > fan_level) ? UP : dn_ok ? DOWN : IDLE;
            UP, DOWN: begin
               clr = 1'b0;
               if (tick) begin
                  state_nxt = (target > fan_level) ? UP : (target < fan_level) ? DOWN : IDLE;
                  level_nxt = (target > fan_level) ? fan_level + 4'd1 :
                              (target < fan_level) ? fan_level - 4'd1 : fan_level;
               end
            end
            OT: state_nxt = (temp_q < OT_HOLD) ? DOWN : OT;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         fan_level <= 4'd0;
         temp_q    <= 4'd0;
      end else begin
         state     <= state_nxt;
         fan_level <= level_nxt;
         if (temp_valid) temp_q <= temp;
      end
   assign fan_on   = fan_level != 4'd0;
   assign overtemp = state == OT;
   assign ramping  = state == UP || state == DOWN;
endmodule

// File: tb/tb_fan_ramp_ctrl.sv
// tb_fan_ramp_ctrl: directed scenarios plus random traffic checked against a cycle-level behavioural model
module tb_fan_ramp_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, enable, temp_valid;
   logic [3:0] temp;
   logic [3:0] fan_level;
   logic       fan_on, overtemp, ramping;
   int tests = 0, fails = 0;
   int m_tq, m_lvl, m_dir, m_left, m_ot, max_lv;
`ifdef FAN_CTRL_HYST_EN
   localparam bit HYST = 1'b1;
`else
   localparam bit HYST = 1'b0;
`endif

   fan_ramp_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .temp_valid(temp_valid),
      .temp      (temp),
      .fan_level (fan_level),
      .fan_on    (fan_on),
      .overtemp  (overtemp),
      .ramping   (ramping)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".level"}, int'(fan_level), m_lvl);
      chk({tag, ".fan_on"}, int'(fan_on), int'(m_lvl != 0));
      chk({tag, ".overtemp"}, int'(overtemp), m_ot);
      chk({tag, ".ramping"}, int'(ramping), int'(m_dir != 0));
   endtask

   task automatic model_reset();
      m_tq = 0; m_lvl = 0; m_dir = 0; m_left = 0; m_ot = 0;
   endtask

   // One rising edge of the reference: target from the rules, one level per RAMP_DIV cycles
   task automatic model_edge();
      int tgt;
      tgt = (m_tq >= 13) ? 15 : (!enable || m_tq < 8) ? 0 : m_tq - 7;
      if (m_tq >= 13 && m_ot == 0) begin
         m_ot = 1; m_lvl = 15; m_dir = 0;
      end else if (m_ot != 0) begin
         if (m_tq <= 11) begin m_ot = 0; m_dir = -1; m_left = 4; end
      end else if (m_dir == 0) begin
         if (tgt > m_lvl) begin m_dir = 1; m_left = 4; end
         else if (tgt < m_lvl && (!HYST || tgt == 0 || tgt <= m_lvl - 2)) begin m_dir = -1; m_left = 4; end
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_left = 4;
            m_dir  = (tgt > m_lvl) ? 1 : (tgt < m_lvl) ? -1 : 0;
            m_lvl += m_dir;
         end
      end
      if (temp_valid) m_tq = int'(temp);
   endtask

   task automatic cyc(input logic v, input logic [3:0] t, input string tag);
      temp_valid = v;
      temp       = t;
      model_edge();
      @(posedge clk);
      #1;
      temp_valid = 1'b0;
      if (int'(fan_level) > max_lv) max_lv = int'(fan_level);
      check_all(tag);
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(1'b0, temp, tag);
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk({tag, ".level"}, int'(fan_level), 0);
      chk({tag, ".fan_on"}, int'(fan_on), 0);
      chk({tag, ".overtemp"}, int'(overtemp), 0);
      chk({tag, ".ramping"}, int'(ramping), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; temp_valid = 1'b0; temp = 4'd0;
      model_reset();
      #1;
      check_all("por");
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      enable = 1'b1;
      // Ramp up to level 3
      cyc(1'b1, 4'd10, "up_cap");
      run(20, "up");
      chk("up_end_level", int'(fan_level), 3);
      chk("up_end_ramping", int'(ramping), 0);
      // Mid-ramp async reset from level 3
      cyc(1'b1, 4'd12, "rst_pre");
      run(3, "rst_pre");
      chk("rst_pre_ramping", int'(ramping), 1);
      async_reset("rst_mid");
      run(6, "rst_post");
      chk("rst_post_level", int'(fan_level), 0);
      // Over-temperature entry, hold and release
      cyc(1'b1, 4'd13, "ot_cap");
      chk("ot_cap_overtemp", int'(overtemp), 0);
      cyc(1'b0, 4'd13, "ot_entry");
      chk("ot_entry_level", int'(fan_level), 15);
      chk("ot_entry_overtemp", int'(overtemp), 1);
      cyc(1'b1, 4'd12, "ot_hold");
      run(6, "ot_hold");
      chk("ot_hold_overtemp", int'(overtemp), 1);
      cyc(1'b1, 4'd11, "ot_rel");
      run(55, "ot_down");
      chk("ot_down_level", int'(fan_level), 4);
      // Disable ramps down to off, over-temp still overrides
      cyc(1'b1, 4'd10, "to3");
      run(10, "to3");
      enable = 1'b0;
      run(20, "dis");
      chk("dis_level", int'(fan_level), 0);
      chk("dis_fan_on", int'(fan_on), 0);
      cyc(1'b1, 4'd13, "dis_ot");
      run(2, "dis_ot");
      chk("dis_ot_level", int'(fan_level), 15);
      chk("dis_ot_overtemp", int'(overtemp), 1);
      // Reversal: ramp toward 5 from level 2, then retarget to 1
      enable = 1'b1;
      cyc(1'b1, 4'd9, "to2");
      run(70, "to2");
      chk("to2_level", int'(fan_level), 2);
      max_lv = 0;
      cyc(1'b1, 4'd12, "rev_up");
      run(5, "rev_up");
      cyc(1'b1, 4'd8, "rev_dn");
      run(20, "rev");
      chk("rev_max", int'(max_lv <= 3), 1);
      chk("rev_level", int'(fan_level), 1);
      // One-below target from level 3 (held only with hysteresis)
      cyc(1'b1, 4'd10, "hy_up");
      run(16, "hy_up");
      cyc(1'b1, 4'd9, "hy_one");
      run(12, "hy_one");
      chk("hy_one_level", int'(fan_level), HYST ? 3 : 2);
      cyc(1'b1, 4'd8, "hy_two");
      run(14, "hy_two");
      chk("hy_two_level", int'(fan_level), 1);
      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) enable = ~enable;
         if ($urandom_range(0, 399) == 0) async_reset("rnd_rst");
         else if ($urandom_range(0, 7) == 0)
            cyc(1'b1, ($urandom_range(0, 1) != 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 15)), "rnd");
         else cyc(1'b0, 4'($urandom_range(0, 15)), "rnd");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
